// File: rtl/quick_cpu_mem.sv
// Byte-wide memory for the quick CPU: zero-latency combinational reads, stores at the clock edge.
// A byte-serial host loader (address byte, then data bytes) takes over the array and stalls the CPU with cpu_hold.
module quick_cpu_mem #(
  parameter int ADDR_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cpu_addr,
  input  logic       cpu_rd,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_hold,
  input  logic       ld_en,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic [7:0] ld_count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_count;

  logic [ADDR_W-1:0] w_idx;
  logic              w_hold;
  logic              w_xfer;
  logic              w_ld_addr;
  logic              w_ld_wr;
  logic              w_cpu_wr;
  logic              w_session_start;
  logic              w_unused_addr_hi;

  assign w_idx            = cpu_addr[ADDR_W-1:0];
  assign w_unused_addr_hi = ^cpu_addr[7:ADDR_W];

  assign w_hold          = (r_state != S_IDLE);
  // Bytes offered while ld_en is low are dropped, even in ADDR/DATA.
  assign w_xfer          = w_hold & ld_en & ld_valid;
  assign w_ld_addr       = w_xfer & (r_state == S_ADDR);
  assign w_ld_wr         = w_xfer & (r_state == S_DATA);
  assign w_cpu_wr        = cpu_wr & ~w_hold;
  assign w_session_start = (r_state == S_IDLE) & ld_en;

  assign cpu_hold  = w_hold;
  assign ld_ready  = w_hold;
  assign ld_count  = r_count;
  assign cpu_rdata = (cpu_rd && !w_hold) ? r_mem[w_idx] : 8'h00;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (ld_en) w_state_nxt = S_ADDR;
      S_ADDR: begin
        if (!ld_en)        w_state_nxt = S_IDLE;
        else if (ld_valid) w_state_nxt = S_DATA;
      end
      S_DATA: if (!ld_en) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_addr) begin
        r_ptr <= ld_data[ADDR_W-1:0];
      end else if (w_ld_wr) begin
        r_ptr <= r_ptr + 1'b1;
      end
      if (w_session_start) begin
        r_count <= '0;
      end else if (w_ld_wr && r_count != 8'hFF) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  // The array is reset too, so an aborted load never leaves stale bytes behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (w_ld_wr) begin
      r_mem[r_ptr] <= ld_data;
    end else if (w_cpu_wr) begin
      r_mem[w_idx] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_quick_cpu_mem.sv
// Directed bench for quick_cpu_mem: inputs change on the falling edge, outputs are checked before the next rising edge.
module tb_quick_cpu_mem;

  logic       clk;
  logic       rst_n;
  logic [7:0] cpu_addr;
  logic       cpu_rd;
  logic       cpu_wr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_hold;
  logic       ld_en;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic [7:0] ld_count;

  int n_tests = 0;
  int n_fail  = 0;

  quick_cpu_mem #(.ADDR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_addr  (cpu_addr),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_hold  (cpu_hold),
    .ld_en     (ld_en),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .ld_count  (ld_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_addr = 8'h00; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = 8'h00;
    ld_en = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cpu_rd = 1'b1; cpu_addr = 8'h03;
    #1;
    n_tests++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got=%h want=00", cpu_rdata); end
    n_tests++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ld_ready got=%b want=0", ld_ready); end
    n_tests++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_hold got=%b want=0", cpu_hold); end
    n_tests++; if (ld_count !== 8'h00) begin n_fail++; $display("FAIL reset_ld_count got=%h want=00", ld_count); end
    tick();
    cpu_rd = 1'b0;
  endtask

  task automatic test_load();
    logic [7:0] bytes [4];
    logic [7:0] addrs [3];
    logic [7:0] exps  [3];
    bytes[0] = 8'h04; bytes[1] = 8'hA1; bytes[2] = 8'hB2; bytes[3] = 8'hC3;
    addrs[0] = 8'h04; addrs[1] = 8'h05; addrs[2] = 8'h06;
    exps[0]  = 8'hA1; exps[1]  = 8'hB2; exps[2]  = 8'hC3;
    ld_en = 1'b1;
    #1;
    n_tests++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL load_hold_same_cycle got=%b want=0", cpu_hold); end
    tick();
    n_tests++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL load_hold_next_cycle got=%b want=1", cpu_hold); end
    n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_addr got=%b want=1", ld_ready); end
    ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_data = bytes[i];
      tick();
    end
    ld_valid = 1'b0;
    #1;
    n_tests++; if (ld_count !== 8'd3) begin n_fail++; $display("FAIL load_count got=%0d want=3", ld_count); end
    ld_en = 1'b0;
    tick();
    n_tests++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL load_hold_drop got=%b want=0", cpu_hold); end
    n_tests++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_drop got=%b want=0", ld_ready); end
    cpu_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_addr = addrs[i];
      #1;
      n_tests++; if (cpu_rdata !== exps[i]) begin n_fail++; $display("FAIL load_readback addr=%h got=%h want=%h", addrs[i], cpu_rdata, exps[i]); end
    end
    n_tests++; if (ld_count !== 8'd3) begin n_fail++; $display("FAIL load_count_holds got=%0d want=3", ld_count); end
    tick();
    cpu_rd = 1'b0;
  endtask

  task automatic test_wrap_alias();
    logic [7:0] addrs [5];
    logic [7:0] exps  [5];
    addrs[0] = 8'h1F; exps[0] = 8'h11;
    addrs[1] = 8'h00; exps[1] = 8'h22;
    addrs[2] = 8'h20; exps[2] = 8'h22;
    addrs[3] = 8'h3F; exps[3] = 8'h11;
    addrs[4] = 8'h01; exps[4] = 8'h00;
    ld_en = 1'b1;
    tick();
    ld_valid = 1'b1;
    ld_data = 8'h1F; tick();
    ld_data = 8'h11; tick();
    ld_data = 8'h22; tick();
    // Byte offered in the same cycle the session closes must be ignored.
    ld_en = 1'b0; ld_data = 8'h77;
    tick();
    ld_valid = 1'b0;
    n_tests++; if (ld_count !== 8'd2) begin n_fail++; $display("FAIL wrap_count got=%0d want=2", ld_count); end
    cpu_rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cpu_addr = addrs[i];
      #1;
      n_tests++; if (cpu_rdata !== exps[i]) begin n_fail++; $display("FAIL wrap_readback addr=%h got=%h want=%h", addrs[i], cpu_rdata, exps[i]); end
    end
    tick();
    cpu_rd = 1'b0;
  endtask

  task automatic test_cpu_store();
    cpu_wr = 1'b1; cpu_addr = 8'h07; cpu_wdata = 8'h5A;
    tick();
    cpu_wr = 1'b0;
    #1;
    n_tests++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL store_rd_low got=%h want=00", cpu_rdata); end
    cpu_rd = 1'b1;
    #1;
    n_tests++; if (cpu_rdata !== 8'h5A) begin n_fail++; $display("FAIL store_readback got=%h want=5A", cpu_rdata); end
    cpu_wr = 1'b1; cpu_wdata = 8'h66;
    #1;
    n_tests++; if (cpu_rdata !== 8'h5A) begin n_fail++; $display("FAIL store_rdwr_old got=%h want=5A", cpu_rdata); end
    tick();
    cpu_wr = 1'b0;
    #1;
    n_tests++; if (cpu_rdata !== 8'h66) begin n_fail++; $display("FAIL store_rdwr_new got=%h want=66", cpu_rdata); end
    tick();
    cpu_rd = 1'b0;
  endtask

  task automatic test_hold();
    ld_en = 1'b1;
    tick();
    cpu_wr = 1'b1; cpu_addr = 8'h02; cpu_wdata = 8'hFF;
    tick();
    cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 8'h05;
    #1;
    n_tests++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL hold_read_blocked got=%h want=00", cpu_rdata); end
    n_tests++; if (ld_count !== 8'd0) begin n_fail++; $display("FAIL hold_count_cleared got=%0d want=0", ld_count); end
    ld_en = 1'b0;
    tick();
    #1;
    n_tests++; if (cpu_rdata !== 8'hB2) begin n_fail++; $display("FAIL hold_read_after got=%h want=B2", cpu_rdata); end
    cpu_addr = 8'h02;
    #1;
    n_tests++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL hold_write_dropped got=%h want=00", cpu_rdata); end
    tick();
    cpu_rd = 1'b0;
  endtask

  task automatic test_reset_mid_session();
    logic [7:0] addrs [3];
    addrs[0] = 8'h08; addrs[1] = 8'h09; addrs[2] = 8'h05;
    ld_en = 1'b1;
    tick();
    ld_valid = 1'b1;
    ld_data = 8'h08; tick();
    ld_data = 8'hAA; tick();
    ld_data = 8'hBB; tick();
    ld_valid = 1'b0;
    #1;
    n_tests++; if (ld_count !== 8'd2) begin n_fail++; $display("FAIL mid_count_before got=%0d want=2", ld_count); end
    rst_n = 1'b0; ld_en = 1'b0;
    #1;
    n_tests++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL mid_reset_hold got=%b want=0", cpu_hold); end
    n_tests++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready got=%b want=0", ld_ready); end
    n_tests++; if (ld_count !== 8'd0) begin n_fail++; $display("FAIL mid_reset_count got=%0d want=0", ld_count); end
    tick();
    rst_n = 1'b1;
    cpu_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_addr = addrs[i];
      #1;
      n_tests++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL mid_reset_cleared addr=%h got=%h want=00", addrs[i], cpu_rdata); end
    end
    tick();
    cpu_rd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_wrap_alias();
    test_cpu_store();
    test_hold();
    test_reset_mid_session();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
